// File: rtl/keypad_pkg.sv
// Shared types and defaults for the matrix keypad scanner and its debouncer.
package keypad_pkg;

    localparam int unsigned DEF_ROWS        = 4;
    localparam int unsigned DEF_COLS        = 4;
    localparam int unsigned DEF_SCAN_DIV    = 1000;
    localparam int unsigned DEF_DEBOUNCE    = 4;
    localparam int unsigned DEF_REPEAT_DLY  = 32;
    localparam int unsigned DEF_REPEAT_RATE = 8;

    // Wide enough for the largest 8x8 matrix; narrowed to CODE_W at the ports.
    localparam int unsigned CAND_CODE_W = 6;
    localparam int unsigned DEB_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } deb_state_t;

    typedef struct packed {
        logic                   none;
        logic [CAND_CODE_W-1:0] code;
    } cand_t;

    localparam cand_t CAND_NONE = '{none: 1'b1, code: '0};

    function automatic int unsigned code_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level press/release debouncer; emits one event per accepted press.
// With KEYPAD_AUTOREPEAT_EN defined, a held key is re-issued periodically.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
    parameter int unsigned REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_RATE = DEF_REPEAT_RATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_stb,
    input  cand_t             cand,
    output logic              evt_c,
    output logic [CODE_W-1:0] evt_code_c,
    output logic              held
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE);

    deb_state_t             state, state_nx;
    logic [DEB_CNT_W-1:0]   cnt, cnt_nx;
    logic [CAND_CODE_W-1:0] acc_code, acc_nx;
    logic                   held_nx;
    logic                   hit_c;
    logic                   press_c;
    logic                   rep_evt_c;

    assign hit_c      = !cand.none && (cand.code == acc_code);
    assign evt_c      = press_c | rep_evt_c;
    assign evt_code_c = CODE_W'(cand.code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_code <= '0;
            held     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            acc_code <= acc_nx;
            held     <= held_nx;
        end
    end

    // acc_code holds the code under test in PRESS_CHK and the accepted code afterwards
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc_code;
        press_c  = 1'b0;
        if (frame_stb) begin
            unique case (state)
                IDLE: begin
                    if (!cand.none) begin
                        state_nx = PRESS_CHK;
                        acc_nx   = cand.code;
                        cnt_nx   = DEB_CNT_W'(1);
                    end
                end
                PRESS_CHK: begin
                    if (cand.none) begin
                        state_nx = IDLE;
                    end else if (hit_c) begin
                        cnt_nx = cnt + DEB_CNT_W'(1);
                    end else begin
                        acc_nx = cand.code;
                        cnt_nx = DEB_CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!hit_c) begin
                        state_nx = REL_CHK;
                        cnt_nx   = DEB_CNT_W'(1);
                    end
                end
                REL_CHK: begin
                    if (hit_c) state_nx = HELD;
                    else       cnt_nx   = cnt + DEB_CNT_W'(1);
                end
                default: state_nx = IDLE;
            endcase
            if (state_nx == PRESS_CHK && cnt_nx >= DEB_LAST) begin
                state_nx = HELD;
                press_c  = 1'b1;
            end
            // A settled change to another key is adopted silently; only "none" releases
            if (state_nx == REL_CHK && cnt_nx >= DEB_LAST) begin
                if (cand.none) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = HELD;
                    acc_nx   = cand.code;
                end
            end
        end
        held_nx = (state_nx == HELD) || (state_nx == REL_CHK);
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
    logic             rep_tick_c;

    assign rep_tick_c = frame_stb && (state == HELD) && hit_c;
    assign rep_evt_c  = rep_tick_c &&
                        ((rep_cnt + REP_W'(1)) == (rep_first ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE)));

    // Frames spent in HELD; first target is REPEAT_DLY, then REPEAT_RATE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (frame_stb) begin
            if (rep_evt_c) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else if (rep_tick_c) begin
                rep_cnt   <= rep_cnt + REP_W'(1);
            end else begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end
        end
    end
`else
    assign rep_evt_c = 1'b0;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// Parametrised matrix keypad scanner: column drive, row sync, frame reduction,
// valid/ready event output with sticky overrun. Optional KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned  ROWS        = DEF_ROWS,
    parameter int unsigned  COLS        = DEF_COLS,
    parameter int unsigned  SCAN_DIV    = DEF_SCAN_DIV,
    parameter int unsigned  DEBOUNCE    = DEF_DEBOUNCE,
    parameter int unsigned  REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int unsigned  REPEAT_RATE = DEF_REPEAT_RATE,
    localparam int unsigned CODE_W      = code_w(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [COLS-1:0]   col_drv,
    input  logic [ROWS-1:0]   row_in,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = $clog2(COLS);

    logic [ROWS-1:0]   row_s1, row_s2;
    logic [DIV_W-1:0]  div_cnt;
    logic [COL_W-1:0]  col_idx;
    logic              slot_end_c, frame_end_c;
    cand_t             acc_cand, col_cand_c, frame_cand_c;
    logic              evt_c, drop_c;
    logic [CODE_W-1:0] evt_code_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign slot_end_c  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end_c = slot_end_c && (col_idx == COL_W'(COLS - 1));

    // Lowest pressed row in the current column; columns are scanned in code order
    always_comb begin
        col_cand_c = CAND_NONE;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (!row_s2[r]) col_cand_c = '{none: 1'b0, code: CAND_CODE_W'(int'(col_idx) * int'(ROWS) + r)};
        end
    end

    assign frame_cand_c = acc_cand.none ? col_cand_c : acc_cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            col_idx  <= '0;
            col_drv  <= ~COLS'(1);
            acc_cand <= CAND_NONE;
        end else if (slot_end_c) begin
            div_cnt  <= '0;
            col_idx  <= frame_end_c ? '0 : col_idx + COL_W'(1);
            col_drv  <= {col_drv[COLS-2:0], col_drv[COLS-1]};
            acc_cand <= frame_end_c ? CAND_NONE : frame_cand_c;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    keypad_debounce #(
        .CODE_W      (CODE_W),
        .DEBOUNCE    (DEBOUNCE),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_stb  (frame_end_c),
        .cand       (frame_cand_c),
        .evt_c      (evt_c),
        .evt_code_c (evt_code_c),
        .held       (key_held)
    );

    assign drop_c = evt_c && key_valid && !key_ready;

    // Output slot: a new event may replace a transferring one; otherwise it is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (evt_c && !drop_c) begin
                key_valid <= 1'b1;
                key_code  <= evt_code_c;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (drop_c)       overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random key traffic
// compared cycle by cycle against a run-length reference model.
module tb_keypad_scanner;

    localparam int unsigned R     = 4;
    localparam int unsigned C     = 4;
    localparam int unsigned SD    = 4;
    localparam int unsigned DB    = 3;
    localparam int unsigned RD    = 4;
    localparam int unsigned RR    = 2;
    localparam int          FRAME = C * SD;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [C-1:0] col_drv;
    logic [R-1:0] row_in;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_ready = 1'b0;
    logic         key_held;
    logic         overrun;
    logic         ovr_clr = 1'b0;
    logic [15:0]  keys = '0;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int e, m_code, m_acc, last_cand, run_same, run_ne, rep_n;
    bit m_valid, m_ovr, m_held;
    int xfers, xfer_code, rise_e;

    keypad_scanner #(
        .ROWS(R), .COLS(C), .SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_DLY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .col_drv(col_drv), .row_in(row_in),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .key_held(key_held), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its driven-low column
    always_comb begin
        row_in = '1;
        for (int c = 0; c < int'(C); c++)
            for (int r = 0; r < int'(R); r++)
                if (!col_drv[c] && keys[c*int'(R)+r]) row_in[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic [31:0] exp_col();
        logic [C-1:0] v;
        v = '1;
        v[(e / int'(SD)) % int'(C)] = 1'b0;
        return 32'(v);
    endfunction

    function automatic int min_code(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic rdy, input logic clr);
        int  cand;
        bit  evt, drop;
        int  ecode;
        evt = 0;
        ecode = 0;
        if (e % FRAME == 0) begin
            cand = min_code(keys);
            if (cand == last_cand) run_same++;
            else begin run_same = 1; last_cand = cand; end
            if (!m_held) begin
                if (cand >= 0 && run_same >= int'(DB)) begin
                    m_held = 1; m_acc = cand; run_ne = 0; rep_n = 0;
                    evt = 1; ecode = cand;
                end
            end else if (cand == m_acc) begin
                if (run_ne == 0) begin
                    rep_n++;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_n == int'(RD) || (rep_n > int'(RD) && (rep_n - int'(RD)) % int'(RR) == 0)) begin
                        evt = 1; ecode = cand;
                    end
`endif
                end else begin
                    rep_n = 0;
                end
                run_ne = 0;
            end else begin
                run_ne++;
                rep_n = 0;
                if (run_ne >= int'(DB)) begin
                    if (cand < 0) m_held = 0;
                    else          m_acc  = cand;
                    run_ne = 0;
                end
            end
        end
        drop = evt && m_valid && !rdy;
        if (evt && !drop)        begin m_valid = 1; m_code = ecode; end
        else if (m_valid && rdy) m_valid = 0;
        if (drop)     m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic step();
        logic rdy, clr, was_valid;
        rdy = key_ready;
        clr = ovr_clr;
        was_valid = key_valid;
        if (key_valid && key_ready) begin xfers++; xfer_code = int'(key_code); end
        @(posedge clk);
        #1;
        e++;
        model_edge(rdy, clr);
        if (!was_valid && key_valid && rise_e < 0) rise_e = e;
        chk("col_drv",   32'(col_drv),   exp_col());
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("key_code",  32'(key_code),  32'(m_code));
        chk("key_held",  32'(key_held),  32'(m_held));
        chk("overrun",   32'(overrun),   32'(m_ovr));
    endtask

    // rmode: 0 = ready low, 1 = ready high, 2 = random ready and occasional ovr_clr
    task automatic frames(input logic [15:0] mask, input int n, input int rmode);
        keys = mask;
        for (int f = 0; f < n * FRAME; f++) begin
            if (rmode == 2) begin
                key_ready = ($urandom_range(0, 9) < 7);
                ovr_clr   = ($urandom_range(0, 19) == 0);
            end else begin
                key_ready = (rmode == 1);
                ovr_clr   = 1'b0;
            end
            step();
        end
        ovr_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        keys = '0;
        key_ready = 1'b0;
        ovr_clr = 1'b0;
        #1;
        chk("rst_col_drv",   32'(col_drv),   32'h0000_000e);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_code",  32'(key_code),  32'd0);
        chk("rst_key_held",  32'(key_held),  32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0; m_valid = 0; m_code = 0; m_ovr = 0; m_held = 0; m_acc = 0;
        last_cand = -1; run_same = 0; run_ne = 0; rep_n = 0;
        xfers = 0; xfer_code = -1; rise_e = -1;
    endtask

    initial begin
        logic [15:0] m;
        int k;
        #2;
        // reset and column rotation
        do_reset();
        frames('0, 2, 1);

        // single clean press of key 6
        do_reset();
        frames(16'h0040, 6, 1);
        frames('0, 4, 1);
        chk("s2_events", 32'(xfers),     32'd1);
        chk("s2_code",   32'(xfer_code), 32'd6);
        chk("s2_rise",   32'(rise_e),    32'(3 * FRAME));

        // bounce: 2 present, 1 absent, 3 present
        do_reset();
        frames(16'h0040, 2, 1);
        frames('0, 1, 1);
        frames(16'h0040, 3, 1);
        frames('0, 4, 1);
        chk("s3_events", 32'(xfers),  32'd1);
        chk("s3_rise",   32'(rise_e), 32'(6 * FRAME));

        // keys 9 and 6 together, then 6 released with 9 still down
        do_reset();
        frames(16'h0240, 4, 1);
        frames(16'h0200, 5, 1);
        frames('0, 4, 1);
        chk("s4_events", 32'(xfers),     32'd1);
        chk("s4_code",   32'(xfer_code), 32'd6);

        // consumer stalled: second event dropped
        do_reset();
        frames(16'h0040, 4, 0);
        frames('0, 4, 0);
        frames(16'h0200, 4, 0);
        frames('0, 4, 0);
        chk("s5_code",    32'(key_code), 32'd6);
        chk("s5_overrun", 32'(overrun),  32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("s5_ovr_clr", 32'(overrun), 32'd0);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        step();
        chk("s5_xfers",   32'(xfers),     32'd1);
        chk("s5_xcode",   32'(xfer_code), 32'd6);
        chk("s5_drained", 32'(key_valid), 32'd0);

        // long hold, then reset while held
        do_reset();
        frames(16'h0040, 12, 1);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("s6_events", 32'(xfers), 32'd4);
`else
        chk("s6_events", 32'(xfers), 32'd1);
`endif
        keys = 16'h0040;
        for (int i = 0; i < 5; i++) step();
        chk("s6_held_before", 32'(key_held), 32'd1);
        do_reset();

        // random key traffic with random back-pressure
        m = '0;
        for (int f = 0; f < 80; f++) begin
            k = int'($urandom_range(0, 9));
            if (k >= 6 && k < 8) begin
                m = '0;
            end else if (k >= 8) begin
                m = '0;
                m[$urandom_range(0, 15)] = 1'b1;
                if ($urandom_range(0, 1) == 1) m[$urandom_range(0, 15)] = 1'b1;
            end
            frames(m, 1, 2);
        end
        frames('0, 5, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
